// File: rtl/multdiv_pkg.sv
// Shared types and defaults for the multiply/divide control sequencer.
package multdiv_pkg;

  localparam int STEPS_DEF = 32;
  localparam int CNT_W_DEF = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/multdiv_if.sv
// Control bundle between decode/execute, the multdiv sequencer and its datapath.
interface multdiv_if #(parameter int CNT_W = 6);
  import multdiv_pkg::*;

  // Handshake: ctrl_mult/ctrl_div are single-cycle start pulses, accepted only
  // while busy=0 (otherwise dropped, never queued); data_ready is a one-cycle
  // completion pulse and data_exception is meaningful only alongside it.
  logic             ctrl_mult;
  logic             ctrl_div;
  logic             divisor_zero;
  logic             load_en;
  logic             acc_clr;
  logic             step_en;
  logic             op_is_div;
  logic [CNT_W-1:0] step_count;
  logic             busy;
  logic             pipe_stall;
  logic             data_ready;
  logic             data_exception;
  state_t           dbg_state;

  modport master (
    output ctrl_mult, ctrl_div, divisor_zero,
    input  load_en, acc_clr, step_en, op_is_div, step_count,
           busy, pipe_stall, data_ready, data_exception, dbg_state
  );

  modport slave (
    input  ctrl_mult, ctrl_div, divisor_zero,
    output load_en, acc_clr, step_en, op_is_div, step_count,
           busy, pipe_stall, data_ready, data_exception, dbg_state
  );

endinterface

// File: rtl/multdiv_step_counter.sv
// Iteration counter with synchronous clear, enable and a terminal count at STEPS-1.
module multdiv_step_counter #(
  parameter int STEPS = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == CNT_W'(STEPS - 1));

endmodule

// File: rtl/multdiv_ctrl.sv
// Sequencer for the iterative multiply/divide unit: load, iterate, complete,
// with pipeline stall and divide-by-zero short-circuit.
module multdiv_ctrl
  import multdiv_pkg::*;
#(
  parameter int STEPS = STEPS_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       clr,
  multdiv_if.slave   bus
);

  state_t     state;
  state_t     state_nxt;
  logic       op_div;
  logic       exc_flag;
  logic       start;
  logic       cnt_clr;
  logic       cnt_en;
  logic       tc;
  logic [CNT_W-1:0] count;

  // Reset has priority over a start arriving in the same cycle.
  assign start = (bus.ctrl_mult | bus.ctrl_div) & ~clr;

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (bus.ctrl_mult || !bus.divisor_zero) begin
            state_nxt = LOAD;
            cnt_clr   = 1'b1;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      LOAD: begin
        cnt_clr   = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        // Hold at STEPS-1 on the last step so the index never wraps.
        cnt_en = ~tc;
        if (tc) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= IDLE;
      op_div   <= 1'b0;
      exc_flag <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        op_div   <= ~bus.ctrl_mult;
        exc_flag <= ~bus.ctrl_mult & bus.divisor_zero;
      end else if (state == DONE) begin
        exc_flag <= 1'b0;
      end
    end
  end

  multdiv_step_counter #(
    .STEPS (STEPS),
    .CNT_W (CNT_W)
  ) u_step_counter (
    .clk   (clk),
    .clr   (clr | cnt_clr),
    .en    (cnt_en),
    .count (count),
    .tc    (tc)
  );

  assign bus.load_en        = (state == LOAD);
  assign bus.acc_clr        = (state == LOAD);
  assign bus.step_en        = (state == RUN);
  assign bus.data_ready     = (state == DONE);
  assign bus.data_exception = (state == DONE) & exc_flag;
  assign bus.op_is_div      = op_div;
  assign bus.step_count     = count;
  assign bus.busy           = (state != IDLE);
  assign bus.pipe_stall     = ((state == IDLE) & start) | (state == LOAD) | (state == RUN);
  assign bus.dbg_state      = state;

endmodule
